// File: rtl/icache_refill_unit.sv
// ICache miss handler: victim-cache probe, 16-beat memory burst assembly and victim writeback.
// Build option VICTIM_PROBE_EN lets a victim-cache hit satisfy the miss; without it every miss goes to memory.
//
// state    | meaning
// IDLE     | waiting for a miss
// PROBE    | victim cache probed with the registered {tag,index}
// MEM_REQ  | burst request held until memory accepts
// MEM_RECV | collecting beats into the line buffer
// RESP     | one-cycle refill pulse
// VW_IDLE  | no victim write in progress
// VW_HOLD1 | victim write enable high, first cycle
// VW_HOLD2 | victim write enable high, second cycle
// VW_GAP   | enable low, tag/data still held so the edge detector settles
module icache_refill_unit #(
   parameter int TAG_WIDTH    = 20,
   parameter int INDEX_WIDTH  = 6,
   parameter int OFFSET_WIDTH = 6,
   parameter int BEATS        = 16
) (
   input  logic                               clk_i,
   input  logic                               rst_i,
   input  logic                               miss_req_i,
   output logic                               miss_ready_o,
   input  logic [31:0]                        miss_addr_i,
   input  logic                               evict_valid_i,
   input  logic [TAG_WIDTH+INDEX_WIDTH-1:0]   evict_tag_i,
   input  logic [BEATS*32-1:0]                evict_data_i,
   output logic [TAG_WIDTH+INDEX_WIDTH-1:0]   vc_r_tag_o,
   input  logic                               vc_hit_i,
   input  logic [BEATS*32-1:0]                vc_data_i,
   output logic [TAG_WIDTH+INDEX_WIDTH-1:0]   vc_w_tag_o,
   output logic                               vc_we_o,
   output logic [BEATS*32-1:0]                vc_w_data_o,
   output logic                               rd_req_o,
   input  logic                               rd_ready_i,
   output logic [31:0]                        rd_addr_o,
   input  logic                               ret_valid_i,
   input  logic                               ret_last_i,
   input  logic [31:0]                        ret_data_i,
   output logic                               refill_valid_o,
   output logic [BEATS*32-1:0]                refill_data_o,
   output logic                               refill_from_vc_o
);

   localparam int LW = TAG_WIDTH + INDEX_WIDTH;
   localparam int CW = $clog2(BEATS);

   typedef enum logic [2:0] {IDLE, PROBE, MEM_REQ, MEM_RECV, RESP} state_e;
   typedef enum logic [1:0] {VW_IDLE, VW_HOLD1, VW_HOLD2, VW_GAP} vw_e;

   state_e               state_q, state_d;
   vw_e                  vw_q, vw_d;
   logic [CW-1:0]        cnt_q;
   logic [BEATS*32-1:0]  line_q;
   logic [LW-1:0]        tag_q;
   logic                 ev_valid_q;
   logic [LW-1:0]        ev_tag_q;
   logic [BEATS*32-1:0]  ev_data_q;
   logic                 accept;
   logic                 unused_sink;

   always_comb begin
      state_d      = state_q;
      vw_d         = vw_q;
      miss_ready_o = (state_q == IDLE) && (vw_q == VW_IDLE);
      accept       = miss_req_i && miss_ready_o;

      case (state_q)
         IDLE:     if (accept) state_d = PROBE;
`ifdef VICTIM_PROBE_EN
         PROBE:    state_d = vc_hit_i ? RESP : MEM_REQ;
`else
         PROBE:    state_d = MEM_REQ;
`endif
         MEM_REQ:  if (rd_ready_i) state_d = MEM_RECV;
         MEM_RECV: if (ret_valid_i && ret_last_i) state_d = RESP;
         RESP:     state_d = IDLE;
         default:  state_d = IDLE;
      endcase

      // Writeback starts on the edge into RESP so the enable is already high in the refill cycle.
      case (vw_q)
         VW_IDLE:  if (state_d == RESP && ev_valid_q) vw_d = VW_HOLD1;
         VW_HOLD1: vw_d = VW_HOLD2;
         VW_HOLD2: vw_d = VW_GAP;
         VW_GAP:   vw_d = VW_IDLE;
         default:  vw_d = VW_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         vw_q       <= VW_IDLE;
         cnt_q      <= '0;
         line_q     <= '0;
         tag_q      <= '0;
         ev_valid_q <= 1'b0;
         ev_tag_q   <= '0;
         ev_data_q  <= '0;
      end else begin
         state_q <= state_d;
         vw_q    <= vw_d;
         if (accept) begin
            tag_q      <= miss_addr_i[31:OFFSET_WIDTH];
            ev_valid_q <= evict_valid_i;
            ev_tag_q   <= evict_tag_i;
            ev_data_q  <= evict_data_i;
            line_q     <= '0;
            cnt_q      <= '0;
         end
`ifdef VICTIM_PROBE_EN
         if (state_q == PROBE && vc_hit_i) line_q <= vc_data_i;
`endif
         if (state_q == MEM_RECV && ret_valid_i) begin
            line_q[{cnt_q, 5'd0} +: 32] <= ret_data_i;
            cnt_q                       <= cnt_q + 1'b1;
         end
      end
   end

`ifdef VICTIM_PROBE_EN
   logic from_vc_q;

   always_ff @(posedge clk_i) begin
      if (rst_i)                          from_vc_q <= 1'b0;
      else if (accept)                    from_vc_q <= 1'b0;
      else if (state_q == PROBE && vc_hit_i) from_vc_q <= 1'b1;
   end

   assign refill_from_vc_o = from_vc_q;
   assign unused_sink      = ^miss_addr_i[OFFSET_WIDTH-1:0];
`else
   assign refill_from_vc_o = 1'b0;
   assign unused_sink      = ^{miss_addr_i[OFFSET_WIDTH-1:0], vc_hit_i, vc_data_i};
`endif

   assign vc_r_tag_o     = tag_q;
   assign rd_addr_o      = {tag_q, {OFFSET_WIDTH{1'b0}}};
   assign rd_req_o       = (state_q == MEM_REQ);
   assign refill_valid_o = (state_q == RESP);
   assign refill_data_o  = line_q;
   assign vc_we_o        = (vw_q == VW_HOLD1) || (vw_q == VW_HOLD2);
   assign vc_w_tag_o     = ev_tag_q;
   assign vc_w_data_o    = ev_data_q;

endmodule
